// File: rtl/marauder_seq.sv
// Instruction sequencer for the alu/alu_regs datapath: accepts one instruction,
// drives read selects and opcode, captures the ALU result and issues the write-back.
module marauder_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [2:0]        alu_opcode,
  output logic [2:0]        rd_slct_a,
  output logic [2:0]        rd_slct_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] wb_data,
  output logic [6:0]        wrt_slct,
  output logic              wrtnbl,
  output logic              busy,
  output logic              done,
  output logic              bank_err,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DEST_W = 7;
  localparam logic [SEL_W-1:0] SEL_RST = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              xfer_c;
  logic              bank_ok_c;
  logic [DEST_W-1:0] dest_q;
  logic              zero_q;
  logic              carry_q;

  // Ready is a pure decode of state so the source sees it without added latency.
  assign instr_ready = (state == S_IDLE) || (state == S_WB);
  assign xfer_c      = instr_valid && instr_ready;
  assign bank_ok_c   = (dest_q[6:4] == 3'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer_c) state_nxt = S_READ;
      S_READ:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = xfer_c ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs; selects only move on a transfer so the LFSR never sees a stray toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode  <= 3'd0;
      rd_slct_a   <= SEL_RST;
      rd_slct_b   <= SEL_RST;
      dest_q      <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      wb_data     <= '0;
      wrt_slct    <= '0;
      wrtnbl      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bank_err    <= 1'b0;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      instr_count <= '0;
    end else begin
      done     <= 1'b0;
      wrtnbl   <= 1'b0;
      bank_err <= 1'b0;
      busy     <= (state_nxt != S_IDLE);
      if (xfer_c) begin
        alu_opcode <= instr[15:13];
        rd_slct_a  <= instr[12:10];
        rd_slct_b  <= instr[9:7];
        dest_q     <= instr[6:0];
      end
      if (state == S_EXEC) begin
        wb_data  <= alu_c;
        zero_q   <= alu_zero;
        carry_q  <= alu_carry;
        wrt_slct <= dest_q;
        done     <= 1'b1;
        wrtnbl   <= bank_ok_c;
        bank_err <= !bank_ok_c;
      end
      if (state == S_WB) begin
        flag_zero   <= zero_q;
        flag_carry  <= carry_q;
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_marauder_seq.sv
// Randomized bench for marauder_seq against a transaction-age reference model,
// with directed cases for reset, back-to-back issue, bank errors and count wrap.
module tb_marauder_seq;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        alu_opcode;
  logic [2:0]        rd_slct_a;
  logic [2:0]        rd_slct_b;
  logic [DATA_W-1:0] alu_c;
  logic              alu_zero;
  logic              alu_carry;
  logic [DATA_W-1:0] wb_data;
  logic [6:0]        wrt_slct;
  logic              wrtnbl;
  logic              busy;
  logic              done;
  logic              bank_err;
  logic              flag_zero;
  logic              flag_carry;
  logic [CNT_W-1:0]  instr_count;

  marauder_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_opcode(alu_opcode), .rd_slct_a(rd_slct_a),
    .rd_slct_b(rd_slct_b), .alu_c(alu_c), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .wb_data(wb_data), .wrt_slct(wrt_slct), .wrtnbl(wrtnbl), .busy(busy), .done(done),
    .bank_err(bank_err), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: age of the in-flight instruction in cycles since acceptance (0 = none).
  int                m_age;
  int                m_acc;
  logic [2:0]        m_op, m_rda, m_rdb;
  logic [6:0]        m_dest, m_ws;
  logic [DATA_W-1:0] m_wb;
  logic              m_z, m_c, m_fz, m_fc;
  logic [CNT_W-1:0]  m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [6:0] d);
    return {op, a, b, d};
  endfunction

  task automatic model_edge();
    logic xfer;
    if (rst) begin
      m_age = 0; m_op = 3'd0; m_rda = 3'b010; m_rdb = 3'b010; m_dest = '0; m_ws = '0;
      m_wb = '0; m_z = 1'b0; m_c = 1'b0; m_fz = 1'b0; m_fc = 1'b0; m_cnt = '0;
    end else begin
      xfer = instr_valid && (m_age == 0 || m_age == 3);
      if (m_age == 2) begin
        m_wb = alu_c; m_z = alu_zero; m_c = alu_carry; m_ws = m_dest;
      end
      if (m_age == 3) begin
        m_fz = m_z; m_fc = m_c; m_cnt = m_cnt + 1'b1;
      end
      if (xfer) begin
        m_op = instr[15:13]; m_rda = instr[12:10]; m_rdb = instr[9:7]; m_dest = instr[6:0];
        m_acc++;
      end
      if (xfer)                         m_age = 1;
      else if (m_age == 1 || m_age == 2) m_age = m_age + 1;
      else                              m_age = 0;
    end
  endtask

  task automatic check_all();
    logic in_wb;
    in_wb = (m_age == 3);
    check("ready",    32'(instr_ready), 32'(m_age == 0 || m_age == 3));
    check("busy",     32'(busy),        32'(m_age != 0));
    check("done",     32'(done),        32'(in_wb));
    check("wrtnbl",   32'(wrtnbl),      32'(in_wb && m_ws[6:4] == 3'd0));
    check("bank_err", 32'(bank_err),    32'(in_wb && m_ws[6:4] != 3'd0));
    check("opcode",   32'(alu_opcode),  32'(m_op));
    check("rd_a",     32'(rd_slct_a),   32'(m_rda));
    check("rd_b",     32'(rd_slct_b),   32'(m_rdb));
    check("wb_data",  32'(wb_data),     32'(m_wb));
    check("wrt_slct", 32'(wrt_slct),    32'(m_ws));
    check("flag_z",   32'(flag_zero),   32'(m_fz));
    check("flag_c",   32'(flag_carry),  32'(m_fc));
    check("count",    32'(instr_count), 32'(m_cnt));
  endtask

  // Inputs are changed only at the negedge; the model samples them at the posedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(input logic [15:0] ins);
    instr = ins; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; instr = 16'($urandom);
  endtask

  initial begin
    m_acc = 0;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    alu_c = '0; alu_zero = 1'b0; alu_carry = 1'b0;
    step(); step();
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_wrtnbl", 32'(wrtnbl), 32'd0);
    check("rst_rd_a", 32'(rd_slct_a), 32'd2);
    check("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b0;

    // Single instruction: op=0, a=2, b=3, dest=A[3]
    issue(mk(3'd0, 3'd2, 3'd3, 7'h03));
    step();
    alu_c = 8'h2A; alu_carry = 1'b0; alu_zero = 1'b0;
    step();
    check("ex_wrtnbl", 32'(wrtnbl), 32'd1);
    check("ex_slct", 32'(wrt_slct), 32'h03);
    check("ex_data", 32'(wb_data), 32'h2A);
    check("ex_done", 32'(done), 32'd1);
    step();

    // Back-to-back with valid held high: second accepted in first's WB
    instr_valid = 1'b1; instr = mk(3'd5, 3'd1, 3'd4, 7'h0C);
    step();
    instr = mk(3'd2, 3'd6, 3'd7, 7'h05);
    alu_c = 8'h11; step(); step();
    check("b2b_done1", 32'(done), 32'd1);
    alu_c = 8'h99; alu_zero = 1'b1; step();
    instr_valid = 1'b0;
    check("b2b_ready_read", 32'(instr_ready), 32'd0);
    step(); step();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_data2", 32'(wb_data), 32'h99);
    step();
    check("b2b_count", 32'(instr_count), 32'd3);

    // Illegal bank
    issue(mk(3'd1, 3'd0, 3'd0, 7'h28));
    step(); step();
    check("berr_flag", 32'(bank_err), 32'd1);
    check("berr_wrtnbl", 32'(wrtnbl), 32'd0);
    step();
    check("berr_count", 32'(instr_count), 32'd4);

    // Reset during EXEC drops the instruction
    issue(mk(3'd3, 3'd5, 3'd5, 7'h01));
    step();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstx_wrtnbl", 32'(wrtnbl), 32'd0);
    end

    // Selects hold while idle
    issue(mk(3'd4, 3'd1, 3'd6, 7'h0A));
    for (int i = 0; i < 23; i++) step();
    check("idle_rd_a", 32'(rd_slct_a), 32'd1);

    // Counter wrap: 16 instructions after reset
    rst = 1'b1; step(); rst = 1'b0;
    m_acc = 0; instr_valid = 1'b1;
    for (int i = 0; i < 200 && m_acc < 16; i++) begin
      instr = 16'($urandom); alu_c = DATA_W'($urandom); step();
    end
    check("wrap_accepted", 32'(m_acc), 32'd16);
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("wrap_count", 32'(instr_count), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      instr_valid = $urandom_range(0, 1) == 1;
      instr       = 16'($urandom);
      if ($urandom_range(0, 1) == 1) instr[6:4] = 3'd0;
      alu_c       = DATA_W'($urandom);
      alu_zero    = 1'($urandom);
      alu_carry   = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
